// File: rtl/bram_fifo_pkg.sv
// Shared types and helpers for the block-RAM first-word-fall-through FIFO.
package bram_fifo_pkg;

   typedef struct packed {
      logic almost_full;
      logic almost_empty;
      logic overflow;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RESET = '{almost_full: 1'b0, almost_empty: 1'b1, overflow: 1'b0};

   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/bram_fifo_sdp_ram.sv
// Simple dual-port synchronous RAM; the read-data register doubles as the FIFO head register.
module sdp_ram_sync #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   localparam int NUM_WORDS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_r [0:NUM_WORDS-1];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Storage array: no reset so the tools can map it onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_r[i_wr_addr] <= i_wr_data;
      end
   end

   // Output register: holds its value unless a new head is loaded.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (i_clr) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (i_rd_en) begin
         rd_data_r <= mem_r[i_rd_addr];
      end
   end

   assign o_rd_data = rd_data_r;

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO: pointer, occupancy and flag control around sdp_ram_sync.
module bram_fifo
   import bram_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH    = 8,
   parameter  int DEPTH         = 256,
   parameter  int AFULL_THRESH  = DEPTH - 4,
   parameter  int AEMPTY_THRESH = 4,
   localparam int ADDR_WIDTH    = ptr_width(DEPTH)
)(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_wr_valid,
   output logic                  o_wr_ready,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic                  o_overflow
);

   typedef logic [ADDR_WIDTH:0]   count_t;
   typedef logic [ADDR_WIDTH-1:0] ptr_t;

   localparam count_t DEPTH_C  = count_t'(DEPTH);
   localparam count_t AFULL_C  = count_t'(AFULL_THRESH);
   localparam count_t AEMPTY_C = count_t'(AEMPTY_THRESH);
   localparam ptr_t   PTR_ONE  = ptr_t'(1'b1);

   count_t      count_r, count_nxt_s, ram_cnt_s;
   ptr_t        wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic        rd_valid_r, rd_valid_nxt_s;
   logic        wr_ready_r, wr_ready_nxt_s;
   fifo_flags_t flags_r, flags_nxt_s;
   logic        push_s, pop_s, load_s, ram_wr_en_s, ram_rd_en_s;

   // Next-state logic; the head register counts toward occupancy but not toward RAM contents.
   always_comb begin
      push_s       = i_wr_valid & wr_ready_r;
      pop_s        = rd_valid_r & i_rd_ready;
      ram_cnt_s    = count_r - count_t'(rd_valid_r);
      load_s       = (ram_cnt_s != {(ADDR_WIDTH+1){1'b0}}) & (~rd_valid_r | pop_s);
      count_nxt_s  = count_r + count_t'(push_s) - count_t'(pop_s);
      wr_ptr_nxt_s = push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_nxt_s = load_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      ram_wr_en_s  = push_s & ~i_clr;
      ram_rd_en_s  = load_s & ~i_clr;

      if (load_s) begin
         rd_valid_nxt_s = 1'b1;
      end else if (pop_s) begin
         rd_valid_nxt_s = 1'b0;
      end else begin
         rd_valid_nxt_s = rd_valid_r;
      end

      wr_ready_nxt_s           = (count_nxt_s < DEPTH_C);
      flags_nxt_s.almost_full  = (count_nxt_s >= AFULL_C);
      flags_nxt_s.almost_empty = (count_nxt_s <= AEMPTY_C);
      flags_nxt_s.overflow     = flags_r.overflow | (i_wr_valid & ~wr_ready_r);
   end

   // Control registers; flush returns everything except the RAM array to the reset state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_r    <= {(ADDR_WIDTH+1){1'b0}};
         wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
         wr_ready_r <= 1'b1;
         flags_r    <= FLAGS_RESET;
      end else if (i_clr) begin
         count_r    <= {(ADDR_WIDTH+1){1'b0}};
         wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
         rd_valid_r <= 1'b0;
         wr_ready_r <= 1'b1;
         flags_r    <= FLAGS_RESET;
      end else begin
         count_r    <= count_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         rd_valid_r <= rd_valid_nxt_s;
         wr_ready_r <= wr_ready_nxt_s;
         flags_r    <= flags_nxt_s;
      end
   end

   sdp_ram_sync #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (i_clr),
      .i_wr_en   (ram_wr_en_s),
      .i_wr_addr (wr_ptr_r),
      .i_wr_data (i_wr_data),
      .i_rd_en   (ram_rd_en_s),
      .i_rd_addr (rd_ptr_r),
      .o_rd_data (o_rd_data)
   );

   assign o_count        = count_r;
   assign o_wr_ready     = wr_ready_r;
   assign o_rd_valid     = rd_valid_r;
   assign o_almost_full  = flags_r.almost_full;
   assign o_almost_empty = flags_r.almost_empty;
   assign o_overflow     = flags_r.overflow;

endmodule

// File: tb/tb_bram_fifo.sv
// Scoreboard bench for bram_fifo (DEPTH=8): directed scenarios followed by randomized traffic.
module tb_bram_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst_n, clr, wr_valid, wr_ready, rd_valid, rd_ready;
   logic [DW-1:0] wr_data, rd_data;
   logic [AW:0]   count;
   logic          almost_full, almost_empty, overflow;

   int checks = 0;
   int errors = 0;

   // reference state: every entry held, oldest first; head visibility and last shown word
   logic [DW-1:0] model_q[$];
   bit            m_valid;
   bit            m_ovf;
   logic [DW-1:0] m_last;

   always #5 clk = ~clk;

   bram_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_clr          (clr),
      .i_wr_valid     (wr_valid),
      .o_wr_ready     (wr_ready),
      .i_wr_data      (wr_data),
      .o_rd_valid     (rd_valid),
      .i_rd_ready     (rd_ready),
      .o_rd_data      (rd_data),
      .o_count        (count),
      .o_almost_full  (almost_full),
      .o_almost_empty (almost_empty),
      .o_overflow     (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: advance the reference one edge using the inputs the DUT saw, then compare outputs.
   always @(posedge clk) begin
      int  ram_before;
      bit  room, do_push, do_pop;
      #1;
      if (!rst_n || clr) begin
         model_q.delete();
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_last  = '0;
      end else begin
         room       = (model_q.size() < DEPTH);
         ram_before = model_q.size() - int'(m_valid);
         do_push    = wr_valid && room;
         do_pop     = m_valid && rd_ready;
         if (wr_valid && !room) m_ovf = 1'b1;
         if (do_pop) void'(model_q.pop_front());
         if (ram_before > 0 && (!m_valid || do_pop)) begin
            m_valid = 1'b1;
            m_last  = model_q[0];
         end else if (do_pop) begin
            m_valid = 1'b0;
         end
         if (do_push) model_q.push_back(wr_data);
      end
      check("count",        count,        model_q.size());
      check("wr_ready",     wr_ready,     (model_q.size() < DEPTH));
      check("rd_valid",     rd_valid,     m_valid);
      check("rd_data",      rd_data,      m_last);
      check("almost_full",  almost_full,  (model_q.size() >= DEPTH - 4));
      check("almost_empty", almost_empty, (model_q.size() <= 4));
      check("overflow",     overflow,     m_ovf);
   end

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      int wr_pct, rd_pct;
      rst_n = 1'b0; clr = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      // reset then idle
      check("idle_wr_ready", wr_ready, 1);
      check("idle_rd_valid", rd_valid, 0);
      check("idle_count", count, 0);
      check("idle_aempty", almost_empty, 1);
      check("idle_overflow", overflow, 0);

      // single word latency
      wr_valid = 1'b1; wr_data = 8'hA5;
      step();
      wr_valid = 1'b0;
      check("lat_not_yet_valid", rd_valid, 0);
      step();
      check("lat_valid", rd_valid, 1);
      check("lat_data", rd_data, 8'hA5);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      check("lat_count_after_pop", count, 0);

      // fill to capacity plus one overflowing write, then drain
      for (int i = 0; i < DEPTH + 1; i++) begin
         wr_valid = 1'b1; wr_data = DW'(i);
         step();
      end
      wr_valid = 1'b0;
      check("full_count", count, DEPTH);
      check("full_wr_ready", wr_ready, 0);
      check("full_overflow", overflow, 1);
      check("full_afull", almost_full, 1);
      rd_ready = 1'b1;
      repeat (DEPTH + 2) step();
      rd_ready = 1'b0;
      check("drained_count", count, 0);
      check("sticky_overflow", overflow, 1);
      clr = 1'b1; step(); clr = 1'b0;

      // preload three, then sustained push+pop
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_data = DW'($urandom);
         step();
      end
      wr_valid = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1; rd_ready = 1'b1; wr_data = DW'($urandom);
         step();
         check("steady_count", count, 3);
         check("steady_valid", rd_valid, 1);
      end
      wr_valid = 1'b0;
      repeat (6) step();
      rd_ready = 1'b0;

      // full with simultaneous write attempt and pop
      for (int i = 0; i < DEPTH; i++) begin
         wr_valid = 1'b1; wr_data = DW'(8'h40 + i);
         step();
      end
      rd_ready = 1'b1;
      step();
      wr_valid = 1'b0; rd_ready = 1'b0;
      check("fullpop_count", count, DEPTH - 1);
      check("fullpop_wr_ready", wr_ready, 1);
      clr = 1'b1; step(); clr = 1'b0;

      // flush colliding with a push
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = DW'($urandom);
         step();
      end
      wr_valid = 1'b0;
      step();
      check("preclr_count", count, 5);
      clr = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
      step();
      clr = 1'b0; wr_valid = 1'b0;
      check("clr_count", count, 0);
      check("clr_rd_valid", rd_valid, 0);
      check("clr_overflow", overflow, 0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_data = DW'($urandom);
         step();
      end
      wr_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_rd_data", rd_data, 0);
      check("arst_wr_ready", wr_ready, 1);
      check("arst_aempty", almost_empty, 1);
      step();
      rst_n = 1'b1;
      step();

      // randomized traffic with shifting producer/consumer rates and rare flushes
      for (int blk = 0; blk < 6; blk++) begin
         wr_pct = $urandom_range(20, 95);
         rd_pct = $urandom_range(20, 95);
         for (int i = 0; i < 500; i++) begin
            wr_valid = ($urandom_range(0, 99) < wr_pct);
            rd_ready = ($urandom_range(0, 99) < rd_pct);
            wr_data  = DW'($urandom);
            clr      = ($urandom_range(0, 299) == 0);
            step();
         end
      end
      wr_valid = 1'b0; rd_ready = 1'b0; clr = 1'b0;
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
